// File: rtl/cpu_trace_pkg.sv
// Shared constants for the instruction-trace buffer: opcodes, capture modes,
// FSM states and entry field layout helpers.
package cpu_trace_pkg;

  // RISC_CPU opcodes
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Capture modes; encoding 3 behaves as STOP_FULL
  localparam logic [1:0] MODE_STOP_FULL = 2'd0;
  localparam logic [1:0] MODE_WRAP      = 2'd1;
  localparam logic [1:0] MODE_HALT_TRIG = 2'd2;

  // Capture FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PEND    = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  // Entry layout, MSB first: {ts, pc, opcode, ir_addr, data}
  function automatic int ent_w(input int ts_w, input int pc_w, input int op_w, input int data_w);
    return ts_w + 2*pc_w + op_w + data_w;
  endfunction
  function automatic int ir_lsb(input int data_w);
    return data_w;
  endfunction
  function automatic int op_lsb(input int pc_w, input int data_w);
    return data_w + pc_w;
  endfunction
  function automatic int pc_lsb(input int pc_w, input int op_w, input int data_w);
    return data_w + pc_w + op_w;
  endfunction
  function automatic int ts_lsb(input int pc_w, input int op_w, input int data_w);
    return data_w + 2*pc_w + op_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace entries. Supports overwrite-oldest when full
// (wrap capture) and a synchronous flush that wins over push/pop.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       ovw_en,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       dropped,
  output logic                       overwrote
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_pop, do_push;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign do_pop    = pop && !empty;
  // a simultaneous pop frees a slot, so full only matters without one
  assign overwrote = push && full && !do_pop && ovw_en;
  assign dropped   = push && full && !do_pop && !ovw_en;
  assign do_push   = push && !dropped;
  // gated so the read port shows zero when nothing is held
  assign rdata     = empty ? '0 : mem[rd_ptr];

  // pointers and occupancy; overwrite advances the read pointer past the lost entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)              wr_ptr <= wr_ptr + 1'b1;
      if (do_pop || overwrote)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop && !overwrote) count <= count + CNT_ONE;
      else if (do_pop && !do_push)          count <= count - CNT_ONE;
    end
  end

  // storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture beside RISC_CPU: detects fetches, delays operand
// sampling by DATA_DLY cycles, filters by opcode and queues entries for a host.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PC_W     = 13,
  parameter int DATA_W   = 8,
  parameter int OP_W     = 3,
  parameter int TS_W     = 16,
  parameter int DATA_DLY = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               clear,
  input  logic [1:0]                         mode,
  input  logic [2**OP_W-1:0]                 op_mask,
  input  logic                               fetch,
  input  logic [PC_W-1:0]                    pc_addr,
  input  logic [PC_W-1:0]                    ir_addr,
  input  logic [OP_W-1:0]                    opcode,
  input  logic [DATA_W-1:0]                  data,
  input  logic                               halt,
  input  logic                               rd_ready,
  output logic                               rd_valid,
  output logic [TS_W+2*PC_W+OP_W+DATA_W-1:0] rd_data,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               overflow,
  output logic                               stopped
);
  localparam int EW = ent_w(TS_W, PC_W, OP_W, DATA_W);

  logic [TS_W-1:0] ts, pend_ts;
  logic [PC_W-1:0] pc_q, pend_pc, evt_pc;
  logic [1:0]      state;
  logic [3:0]      dly;
  logic            halt_q, evt, halt_fire, pend_due, imm_wr, wr_en, ovw_en;
  logic            empty, dropped, overwrote;
  logic [EW-1:0]   wr_data;

  // a new fetch is an odd PC that differs from last cycle's PC
  assign evt       = enable && fetch && pc_addr[0] && (pc_addr != pc_q);
  assign evt_pc    = pc_addr - PC_W'(1);
  assign halt_fire = (mode == MODE_HALT_TRIG) && halt && !halt_q && (state != ST_STOPPED);
  // pending entry completes on its delay expiring, or early when displaced/halted
  assign pend_due  = (state == ST_PEND) && ((dly == 4'd1) || evt || halt_fire);
  assign imm_wr    = (DATA_DLY == 0) && evt && (state == ST_IDLE) && !halt_fire;
  assign wr_en     = (pend_due || imm_wr) && !clear && op_mask[opcode];
  assign ovw_en    = (mode == MODE_WRAP) || (mode == MODE_HALT_TRIG);
  assign wr_data   = pend_due ? {pend_ts, pend_pc, opcode, ir_addr, data}
                              : {ts, evt_pc, opcode, ir_addr, data};
  assign rd_valid  = !empty;

  // free-running timestamp and one-cycle history of PC and halt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts     <= '0;
      pc_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      ts     <= ts + TS_W'(1);
      pc_q   <= pc_addr;
      halt_q <= halt;
    end
  end

  // capture FSM: latch ts/pc on event, count down to operand sample point
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      dly     <= '0;
      pend_ts <= '0;
      pend_pc <= '0;
    end else if (clear) begin
      state   <= ST_IDLE;
      dly     <= '0;
    end else if (state != ST_STOPPED) begin
      if (halt_fire) begin
        state <= ST_STOPPED;
      end else if (evt && (DATA_DLY != 0)) begin
        state   <= ST_PEND;
        dly     <= 4'(DATA_DLY);
        pend_ts <= ts;
        pend_pc <= evt_pc;
      end else if (state == ST_PEND) begin
        if (dly == 4'd1) state <= ST_IDLE;
        dly <= dly - 4'd1;
      end
    end
  end

  // sticky status flags, cleared only by clear/reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      stopped  <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
      stopped  <= 1'b0;
    end else begin
      if (dropped || overwrote) overflow <= 1'b1;
      if (halt_fire)            stopped  <= 1'b1;
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (wr_en),
    .pop       (rd_valid && rd_ready),
    .ovw_en    (ovw_en),
    .wdata     (wr_data),
    .rdata     (rd_data),
    .count     (count),
    .empty     (empty),
    .dropped   (dropped),
    .overwrote (overwrote)
  );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: single capture latency, STOP_FULL,
// WRAP, opcode filter, HALT_TRIG freeze, async reset and full push+pop.
module tb_cpu_trace_buffer;
  import cpu_trace_pkg::*;

  localparam int PC_W = 13, DATA_W = 8, OP_W = 3, TS_W = 16, DLY = 4;
  localparam int EW = TS_W + 2*PC_W + OP_W + DATA_W;

  logic              clk = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0;
  logic              fetch = 1'b0, halt = 1'b0, rd_ready = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [7:0]        op_mask = 8'hFF;
  logic [PC_W-1:0]   pc_addr = '0, ir_addr = '0;
  logic [OP_W-1:0]   opcode = '0;
  logic [DATA_W-1:0] data = '0;
  logic              rd_valid, overflow, stopped;
  logic [EW-1:0]     rd_data;
  logic [4:0]        count;

  int total = 0, bad = 0;
  int cyc;
  logic [PC_W-1:0] nxt_pc = 13'd1;

  cpu_trace_buffer #(.DEPTH(16), .PC_W(PC_W), .DATA_W(DATA_W), .OP_W(OP_W),
                     .TS_W(TS_W), .DATA_DLY(DLY)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .mode(mode),
    .op_mask(op_mask), .fetch(fetch), .pc_addr(pc_addr), .ir_addr(ir_addr),
    .opcode(opcode), .data(data), .halt(halt), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .overflow(overflow), .stopped(stopped)
  );

  always #5 clk = ~clk;

  // cycle reference: value of the timestamp during the current cycle
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // one fetch event, operands held through the sample point; returns expected entry
  task automatic fire(input logic [2:0] op, input logic [PC_W-1:0] ir,
                      input logic [7:0] d, input logic pop_at_wr,
                      output logic [EW-1:0] e);
    fetch = 1'b1; pc_addr = nxt_pc;
    e = {cyc[TS_W-1:0], nxt_pc - 13'd1, op, ir, d};
    nxt_pc = nxt_pc + 13'd2;
    tick();
    fetch = 1'b0; opcode = op; ir_addr = ir; data = d;
    tick(DLY - 1);
    rd_ready = pop_at_wr;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(2); reset = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rd_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL rst_stopped got=%b exp=0", stopped); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", rd_data); end
  endtask

  // T1: fetch of pc 1 at ts=10 lands DLY cycles later
  task automatic test_single();
    logic [EW-1:0] e;
    e = {16'd10, 13'd0, OP_LDA, 13'h0AB, 8'h5A};
    mode = MODE_STOP_FULL; op_mask = 8'hFF; enable = 1'b1;
    tick(10);
    fetch = 1'b1; pc_addr = 13'd1; nxt_pc = 13'd3;
    tick();
    fetch = 1'b0; opcode = OP_LDA; ir_addr = 13'h0AB; data = 8'h5A;
    tick(DLY - 1);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL t1_early_count got=%0d exp=0", count); end
    tick();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL t1_count got=%0d exp=1", count); end
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b exp=1", rd_valid); end
    total++; if (rd_data !== e) begin bad++; $display("FAIL t1_data got=%h exp=%h", rd_data, e); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL t1_pop_count got=%0d exp=0", count); end
  endtask

  // T2: STOP_FULL keeps the first 16, drops the 17th
  task automatic test_stop_full();
    logic [EW-1:0] ev [17];
    do_clear(); mode = MODE_STOP_FULL;
    for (int i = 0; i < 17; i++) fire(OP_ADD, 13'(i), 8'(i + 8'h40), 1'b0, ev[i]);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL t2_count got=%0d exp=16", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t2_ovf got=%b exp=1", overflow); end
    for (int k = 0; k < 16; k++) begin
      total++; if (rd_data !== ev[k]) begin bad++; $display("FAIL t2_entry%0d got=%h exp=%h", k, rd_data, ev[k]); end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL t2_drained got=%b exp=0", rd_valid); end
  endtask

  // T3: WRAP overwrites the two oldest of 18
  task automatic test_wrap();
    logic [EW-1:0] ev [18];
    do_clear(); mode = MODE_WRAP;
    for (int i = 0; i < 18; i++) fire(OP_XOR, 13'(i + 100), 8'(i), 1'b0, ev[i]);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL t3_count got=%0d exp=16", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t3_ovf got=%b exp=1", overflow); end
    for (int k = 0; k < 16; k++) begin
      total++; if (rd_data !== ev[k+2]) begin bad++; $display("FAIL t3_entry%0d got=%h exp=%h", k, rd_data, ev[k+2]); end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL t3_valid got=%b exp=0", rd_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL t3_count_end got=%0d exp=0", count); end
  endtask

  // T4: SKZ masked out, ADD still recorded
  task automatic test_filter();
    logic [EW-1:0] e;
    do_clear(); mode = MODE_STOP_FULL; op_mask = 8'b1111_1101;
    fire(OP_SKZ, 13'h010, 8'h11, 1'b0, e);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL t4_skz_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t4_ovf got=%b exp=0", overflow); end
    fire(OP_ADD, 13'h020, 8'h22, 1'b0, e);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL t4_add_count got=%0d exp=1", count); end
    total++; if (rd_data !== e) begin bad++; $display("FAIL t4_data got=%h exp=%h", rd_data, e); end
    op_mask = 8'hFF;
  endtask

  // T5: halt rise two cycles after an event flushes the pending entry and freezes capture
  task automatic test_halt();
    logic [EW-1:0] e, e2;
    do_clear(); mode = MODE_HALT_TRIG;
    fetch = 1'b1; pc_addr = nxt_pc;
    e = {cyc[TS_W-1:0], nxt_pc - 13'd1, OP_STO, 13'h111, 8'hC3};
    nxt_pc = nxt_pc + 13'd2;
    tick();
    fetch = 1'b0; opcode = OP_STO; ir_addr = 13'h111; data = 8'hC3;
    tick();
    halt = 1'b1;
    tick();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL t5_count got=%0d exp=1", count); end
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL t5_stopped got=%b exp=1", stopped); end
    total++; if (rd_data !== e) begin bad++; $display("FAIL t5_data got=%h exp=%h", rd_data, e); end
    fire(OP_JMP, 13'h222, 8'h77, 1'b0, e2);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL t5_frozen got=%0d exp=1", count); end
    total++; if (rd_data !== e) begin bad++; $display("FAIL t5_head got=%h exp=%h", rd_data, e); end
    do_clear();
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL t5_clr_stopped got=%b exp=0", stopped); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL t5_clr_count got=%0d exp=0", count); end
    fire(OP_AND, 13'h333, 8'h99, 1'b0, e2);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL t5_resume got=%0d exp=1", count); end
    halt = 1'b0;
  endtask

  // T6: push+pop at full, then async reset mid-pending with overflow set
  task automatic test_full_reset();
    logic [EW-1:0] ev [16];
    logic [EW-1:0] e;
    do_clear(); mode = MODE_STOP_FULL;
    for (int i = 0; i < 16; i++) fire(OP_LDA, 13'(i + 200), 8'(i + 8'h80), 1'b0, ev[i]);
    fire(OP_ADD, 13'h0FF, 8'hEE, 1'b1, e);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL t6_pp_count got=%0d exp=16", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t6_pp_ovf got=%b exp=0", overflow); end
    total++; if (rd_data !== ev[1]) begin bad++; $display("FAIL t6_pp_head got=%h exp=%h", rd_data, ev[1]); end
    fire(OP_ADD, 13'h0FE, 8'hDD, 1'b0, e);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t6_drop_ovf got=%b exp=1", overflow); end
    fetch = 1'b1; pc_addr = nxt_pc; nxt_pc = nxt_pc + 13'd2;
    tick();
    fetch = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL t6_rst_count got=%0d exp=0", count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL t6_rst_valid got=%b exp=0", rd_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t6_rst_ovf got=%b exp=0", overflow); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL t6_rst_data got=%h exp=0", rd_data); end
    tick(); reset = 1'b0;
    tick(DLY + 2);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL t6_no_stray got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stop_full();
    test_wrap();
    test_filter();
    test_halt();
    test_full_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete by 100000 time units");
    $fatal(1);
  end

endmodule
